// File: rtl/read_master_pipelined_pkg.sv
// Shared defaults for the pipelined read master slice.
// Also holds the byte-enable width helper.
package read_master_pipelined_pkg;

  localparam int unsigned DATAWIDTH_DEF      = 32;
  localparam int unsigned ADDRESSWIDTH_DEF   = 32;
  localparam int unsigned FIFODEPTH_DEF      = 32;
  localparam int unsigned FIFODEPTH_LOG2_DEF = 5;

  // Byte lanes covered by one data word.
  function automatic int unsigned byteenable_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/read_master_pipelined_if.sv
// Avalon-MM pipelined read bus between the read master and its slave.
interface read_master_pipelined_if
  import read_master_pipelined_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = DATAWIDTH_DEF,
  parameter int unsigned BYTEENABLEWIDTH = byteenable_width(DATAWIDTH_DEF),
  parameter int unsigned ADDRESSWIDTH    = ADDRESSWIDTH_DEF
);

  logic [ADDRESSWIDTH-1:0]    master_address;
  logic                       master_read;
  logic [BYTEENABLEWIDTH-1:0] master_byteenable;
  logic [DATAWIDTH-1:0]       master_readdata;
  logic                       master_readdatavalid;
  logic                       master_waitrequest;

  modport master (
    output master_address,
    output master_read,
    output master_byteenable,
    input  master_readdata,
    input  master_readdatavalid,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_read,
    input  master_byteenable,
    output master_readdata,
    output master_readdatavalid,
    output master_waitrequest
  );

endinterface

// File: rtl/read_master_pipelined_sync_fifo_showahead.sv
// Show-ahead synchronous FIFO: head word is visible on read_data while not empty.
// Pointers carry one extra wrap bit so used/full need no separate counter.
module sync_fifo_showahead
  import read_master_pipelined_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = DATAWIDTH_DEF,
  parameter int unsigned FIFODEPTH      = FIFODEPTH_DEF,
  parameter int unsigned FIFODEPTH_LOG2 = FIFODEPTH_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write,
  input  logic [DATAWIDTH-1:0]      write_data,
  input  logic                      read,
  output logic [DATAWIDTH-1:0]      read_data,
  output logic                      empty,
  output logic                      full,
  output logic [FIFODEPTH_LOG2:0]   used
);

  localparam int unsigned PW = FIFODEPTH_LOG2 + 1;

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign used  = wr_ptr - rd_ptr;
  assign empty = (used == '0);
  assign full  = used[FIFODEPTH_LOG2];

  // A pop frees the head slot in the same edge, so a push into a full FIFO is fine then.
  assign do_pop  = read & ~empty;
  assign do_push = write & (~full | do_pop);

  assign read_data = mem[rd_ptr[FIFODEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[FIFODEPTH_LOG2-1:0]] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/read_master_pipelined.sv
// Avalon-MM pipelined read master: streams a block of words into a show-ahead FIFO.
// Reads are only issued while every outstanding word is guaranteed a FIFO slot.
module read_master_pipelined
  import read_master_pipelined_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = DATAWIDTH_DEF,
  parameter int unsigned BYTEENABLEWIDTH = byteenable_width(DATAWIDTH_DEF),
  parameter int unsigned ADDRESSWIDTH    = ADDRESSWIDTH_DEF,
  parameter int unsigned FIFODEPTH       = FIFODEPTH_DEF,
  parameter int unsigned FIFODEPTH_LOG2  = FIFODEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0] control_read_base,
  input  logic [ADDRESSWIDTH-1:0] control_read_length,
  input  logic                    control_go,
  output logic                    control_done,
  output logic                    control_early_done,
  input  logic                    user_read_buffer,
  output logic [DATAWIDTH-1:0]    user_buffer_data,
  output logic                    user_data_available,
  read_master_pipelined_if.master bus
);

  localparam int unsigned AW = ADDRESSWIDTH;
  localparam int unsigned CW = FIFODEPTH_LOG2 + 1;
  localparam int unsigned SW = FIFODEPTH_LOG2 + 2;

  logic [AW-1:0] address_q, address_d;
  logic [AW-1:0] length_q,  length_d;
  logic          fixed_q,   fixed_d;
  logic [CW-1:0] pending_q, pending_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_used;
  logic          room;
  logic          go_accept;
  logic          accept;

  // Outstanding reads plus stored words must never exceed the FIFO.
  assign room = ~fifo_full & ((SW'(fifo_used) + SW'(pending_q)) < SW'(FIFODEPTH));

  assign bus.master_read       = (length_q != '0) & room;
  assign bus.master_address    = address_q;
  assign bus.master_byteenable = '1;

  assign control_early_done = (length_q == '0);
  assign control_done       = (length_q == '0) & (pending_q == '0);

  assign go_accept = control_go & control_done;
  assign accept    = bus.master_read & ~bus.master_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      length_q  <= '0;
      fixed_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      address_q <= address_d;
      length_q  <= length_d;
      fixed_q   <= fixed_d;
      pending_q <= pending_d;
    end
  end

  // Next-state for the transfer registers; go and accept are mutually exclusive.
  always_comb begin
    address_d = address_q;
    length_d  = length_q;
    fixed_d   = fixed_q;
    pending_d = pending_q;

    if (go_accept) begin
      address_d = control_read_base;
      length_d  = control_read_length;
      fixed_d   = control_fixed_location;
    end else if (accept) begin
      length_d = length_q - AW'(1);
      if (!fixed_q) begin
        address_d = address_q + AW'(1);
      end
    end

    // A stray readdatavalid with nothing outstanding leaves pending at zero.
    unique case ({accept, bus.master_readdatavalid})
      2'b10:   pending_d = pending_q + CW'(1);
      2'b01:   if (pending_q != '0) pending_d = pending_q - CW'(1);
      default: pending_d = pending_q;
    endcase
  end

  sync_fifo_showahead #(
    .DATAWIDTH      (DATAWIDTH),
    .FIFODEPTH      (FIFODEPTH),
    .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .write      (bus.master_readdatavalid),
    .write_data (bus.master_readdata),
    .read       (user_read_buffer),
    .read_data  (user_buffer_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .used       (fifo_used)
  );

  assign user_data_available = ~fifo_empty;

endmodule
